// File: rtl/mul_div_unit.sv
// Iterative 32x32 multiply / divide unit with HI/LO registers (MULT, MULTU, DIV, DIVU, MTHI, MTLO).
// Divide support is compiled in only when MDU_DIV_EN is defined.
module mul_div_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Start,
  input  logic [1:0]  MDOp,
  input  logic [31:0] SrcA,
  input  logic [31:0] SrcB,
  input  logic        HiWe,
  input  logic        LoWe,
  input  logic [31:0] WData,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] opnd_q, opnd_d;
  logic [63:0] acc_q, acc_d;
  logic        neg_a_q, neg_a_d;
  logic        neg_b_q, neg_b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
`ifdef MDU_DIV_EN
  logic        is_div_q, is_div_d;
`endif

  logic        start_ok;
  logic        sgn_a, sgn_b;
  logic [31:0] mag_a, mag_b;
  logic [32:0] mul_sum;
  logic [63:0] mul_next;
  logic [63:0] step_next;
  logic [63:0] mul_res;
`ifdef MDU_DIV_EN
  logic [33:0] div_trial;
  logic [63:0] div_next;
  logic [31:0] quo_res;
  logic [31:0] rem_res;
`endif

  // Signed operations run on magnitudes; signs are reapplied in StFix.
  always_comb begin
    sgn_a = ~MDOp[0] & SrcA[31];
    sgn_b = ~MDOp[0] & SrcB[31];
    mag_a = sgn_a ? (32'd0 - SrcA) : SrcA;
    mag_b = sgn_b ? (32'd0 - SrcB) : SrcB;
`ifdef MDU_DIV_EN
    start_ok = Start;
`else
    start_ok = Start & ~MDOp[1];
`endif
  end

  // Shift-add: acc = {partial product, remaining multiplier bits}.
  always_comb begin
    mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    mul_next = {mul_sum, acc_q[31:1]};
    mul_res  = (neg_a_q ^ neg_b_q) ? (64'd0 - acc_q) : acc_q;
  end

`ifdef MDU_DIV_EN
  // Restoring divide: acc = {partial remainder, dividend bits / quotient bits}.
  always_comb begin
    div_trial = {1'b0, acc_q[63:31]} - {2'b00, opnd_q};
    div_next  = div_trial[33] ? {acc_q[62:0], 1'b0} : {div_trial[31:0], acc_q[30:0], 1'b1};
    rem_res   = neg_a_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
    if (opnd_q == 32'd0) begin
      quo_res = 32'hFFFF_FFFF;
    end else begin
      quo_res = (neg_a_q ^ neg_b_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    end
    step_next = is_div_q ? div_next : mul_next;
  end
`else
  always_comb begin
    step_next = mul_next;
  end
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    neg_a_d  = neg_a_q;
    neg_b_d  = neg_b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
`ifdef MDU_DIV_EN
    is_div_d = is_div_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start_ok) begin
          state_d = StCalc;
          cnt_d   = 5'd0;
          neg_a_d = sgn_a;
          neg_b_d = sgn_b;
          acc_d   = {32'd0, mag_b};
          opnd_d  = mag_a;
`ifdef MDU_DIV_EN
          is_div_d = MDOp[1];
          if (MDOp[1]) begin
            acc_d  = {32'd0, mag_a};
            opnd_d = mag_b;
          end
`endif
        end else begin
          if (HiWe) hi_d = WData;
          if (LoWe) lo_d = WData;
        end
      end
      StCalc: begin
        acc_d = step_next;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = StFix;
      end
      StFix: begin
        state_d      = StIdle;
        done_d       = 1'b1;
        {hi_d, lo_d} = mul_res;
`ifdef MDU_DIV_EN
        if (is_div_q) begin
          hi_d = rem_res;
          lo_d = quo_res;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= 5'd0;
      opnd_q   <= 32'd0;
      acc_q    <= 64'd0;
      neg_a_q  <= 1'b0;
      neg_b_q  <= 1'b0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
`ifdef MDU_DIV_EN
      is_div_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      neg_a_q  <= neg_a_d;
      neg_b_q  <= neg_b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
`ifdef MDU_DIV_EN
      is_div_q <= is_div_d;
`endif
    end
  end

  assign Busy = (state_q != StIdle);
  assign Done = done_q;
  assign Hi   = hi_q;
  assign Lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed bench for mul_div_unit: expected HI/LO queued at Start, compared when Done pulses.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        Start = 1'b0;
  logic [1:0]  MDOp = 2'b00;
  logic [31:0] SrcA = 32'd0;
  logic [31:0] SrcB = 32'd0;
  logic        HiWe = 1'b0;
  logic        LoWe = 1'b0;
  logic [31:0] WData = 32'd0;
  logic        Busy;
  logic        Done;
  logic [31:0] Hi;
  logic [31:0] Lo;

  int n_checks = 0;
  int n_pass = 0;
  logic [63:0] exp_q[$];

  mul_div_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Start (Start),
    .MDOp  (MDOp),
    .SrcA  (SrcA),
    .SrcB  (SrcB),
    .HiWe  (HiWe),
    .LoWe  (LoWe),
    .WData (WData),
    .Busy  (Busy),
    .Done  (Done),
    .Hi    (Hi),
    .Lo    (Lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    logic [63:0] p;
    logic [31:0] q;
    logic [31:0] r;
    case (op)
      2'b00: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      2'b01: p = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = {32'd0, 32'h8000_0000};
        else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          p = {r, q};
        end
      end
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // ign_at / hiwe_at: after which edge index to inject an ignored Start / HiWe.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input string tag, input int ign_at, input int hiwe_at);
    int lat;
    logic stable;
    logic [31:0] hi0, lo0;
    logic [63:0] e;
    hi0 = Hi;
    lo0 = Lo;
    MDOp = op;
    SrcA = a;
    SrcB = b;
    Start = 1'b1;
    exp_q.push_back(model(op, a, b));
    step;
    Start = 1'b0;
    HiWe = 1'b0;
    LoWe = 1'b0;
    lat = 0;
    stable = 1'b1;
    while (Done !== 1'b1 && lat < 40) begin
      if (Busy !== 1'b1 || Hi !== hi0 || Lo !== lo0) stable = 1'b0;
      if (lat == ign_at) begin
        Start = 1'b1;
        MDOp = 2'b01;
        SrcA = 32'd7;
        SrcB = 32'd9;
      end
      if (lat == ign_at + 1) Start = 1'b0;
      if (lat == hiwe_at) begin
        HiWe = 1'b1;
        WData = 32'h1234;
      end
      if (lat == hiwe_at + 1) HiWe = 1'b0;
      step;
      lat++;
    end
    Start = 1'b0;
    HiWe = 1'b0;
    check({tag, " latency"}, lat, 33);
    check({tag, " busy/hilo stable"}, stable, 1);
    check({tag, " busy after done"}, Busy, 0);
    if (exp_q.size() == 0) e = 64'hX;
    else e = exp_q.pop_front();
    check({tag, " result"}, {Hi, Lo}, e);
    step;
    check({tag, " done pulse width"}, Done, 0);
  endtask

  task automatic run_ignored_div;
    logic [31:0] hi0, lo0;
    logic seen;
    hi0 = Hi;
    lo0 = Lo;
    MDOp = 2'b10;
    SrcA = 32'hFFFF_FFF9;
    SrcB = 32'd2;
    Start = 1'b1;
    step;
    Start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 36; i++) begin
      if (Busy !== 1'b0 || Done !== 1'b0) seen = 1'b1;
      step;
    end
    check("div disabled no busy/done", seen, 0);
    check("div disabled hilo", {Hi, Lo}, {hi0, lo0});
  endtask

  initial begin
    logic seen;
    #1 rst_n = 1'b0;
    #10;
    check("reset busy", Busy, 0);
    check("reset done", Done, 0);
    check("reset hi", Hi, 0);
    check("reset lo", Lo, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(2'b00, 32'hFFFF_FFFE, 32'd3, "mult -2*3", -10, -10);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu max", -10, -10);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult minneg^2", -10, -10);
    run_op(2'b00, 32'd7, 32'hFFFF_FFFB, "mult 7*-5", -10, -10);

`ifdef MDU_DIV_EN
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, "div -7/2", -10, -10);
    run_op(2'b11, 32'd100, 32'd0, "divu 100/0", -10, -10);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div overflow", -10, -10);
    run_op(2'b10, 32'd100, 32'hFFFF_FFF9, "div 100/-7", -10, -10);
    run_op(2'b11, 32'hFFFF_FFFF, 32'd10, "divu max/10", -10, -10);
    run_op(2'b10, 32'hFFFF_FFFB, 32'd0, "div -5/0", -10, -10);
`else
    run_ignored_div();
`endif

    // MTHI and MTLO together
    HiWe = 1'b1;
    LoWe = 1'b1;
    WData = 32'h55AA;
    step;
    HiWe = 1'b0;
    LoWe = 1'b0;
    check("mthi+mtlo", {Hi, Lo}, {32'h55AA, 32'h55AA});

    // Start with HiWe: write must be dropped (stable check catches an early Hi change)
    HiWe = 1'b1;
    WData = 32'hDEAD;
    run_op(2'b01, 32'd2, 32'd3, "start+hiwe", -10, -10);

    // Ignored Start at E5 and ignored HiWe at E10
    run_op(2'b01, 32'd5, 32'd6, "multu ignored start", 4, 9);
    LoWe = 1'b1;
    WData = 32'hABCD;
    step;
    LoWe = 1'b0;
    check("mtlo after done", {Hi, Lo}, {32'd0, 32'hABCD});

    // Reset mid-operation at E16
    MDOp = 2'b00;
    SrcA = 32'd3;
    SrcB = 32'hFFFF_FFFF;
    Start = 1'b1;
    exp_q.push_back(model(2'b00, 32'd3, 32'hFFFF_FFFF));
    step;
    Start = 1'b0;
    for (int i = 0; i < 15; i++) step;
    #2 rst_n = 1'b0;
    #1;
    check("mid reset busy", Busy, 0);
    check("mid reset hilo", {Hi, Lo}, 64'd0);
    exp_q.delete();
    step;
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (Done !== 1'b0 || Busy !== 1'b0) seen = 1'b1;
      step;
    end
    check("no done after reset", seen, 0);
    run_op(2'b00, 32'd3, 32'hFFFF_FFFF, "mult after reset", -10, -10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", n_pass, n_checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mul_div_unit.md
MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, and SHALL expose exactly these ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- Start  in  1  one-cycle request to begin an operation.
- MDOp  in  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- SrcA  in  32  rs operand (multiplicand / dividend).
- SrcB  in  32  rt operand (multiplier / divisor).
- HiWe  in  1  MTHI write enable.
- LoWe  in  1  MTLO write enable.
- WData  in  32  MTHI/MTLO data.
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle pulse: HI/LO just updated by an operation.
- Hi  out  32  HI register.
- Lo  out  32  LO register.

Function
REQ-002 The FSM SHALL have exactly three states: IDLE, CALC and FIX.
REQ-003 In IDLE with Start=1 at edge E0, the block SHALL latch SrcA, SrcB and MDOp, and SHALL enter CALC with iteration counter=0.
REQ-004 The block SHALL remain in CALC for exactly 32 edges (counter 0..31, one bit per edge), then enter FIX.
- Multiply: shift-add.
- Divide: restoring.
- Signed ops: operate on magnitudes.
REQ-005 FIX SHALL last one edge (E33), during which the block SHALL:
- apply sign correction;
- write Hi/Lo;
- return to IDLE.
REQ-006 Done SHALL be registered and high for exactly the one cycle after E33; otherwise 0.
REQ-007 Busy SHALL be 1 from after E0 through E33 inclusive, 0 otherwise; a new Start is accepted at E34 at the earliest.
REQ-008 MULT/MULTU SHALL produce the 64-bit product with {Hi,Lo} = product.
- MULT: signed two's-complement operands.
- MULTU: unsigned operands.
REQ-009 DIV/DIVU SHALL set Lo=quotient and Hi=remainder.
- Signed quotient truncates toward zero.
- Signed remainder takes the sign of the dividend.
REQ-010 Divide by zero SHALL give Lo=32'hFFFFFFFF and Hi=SrcA, for both signed and unsigned.
REQ-011 DIV of 32'h80000000 by 32'hFFFFFFFF SHALL give Lo=32'h80000000 and Hi=0.
REQ-012 Start while Busy=1 SHALL be ignored, with no effect on the operation in progress.
REQ-013 HiWe/LoWe in IDLE SHALL write WData to Hi/Lo at the next edge; HiWe and LoWe together SHALL write both registers.
REQ-014 HiWe/LoWe while Busy=1 SHALL be ignored.
REQ-015 Start together with HiWe/LoWe in IDLE SHALL start the operation and drop the writes.
REQ-016 Hi/Lo SHALL be unchanged between E0 and E33; no intermediate values SHALL be visible.

Reset
REQ-017 rst_n=0 SHALL immediately, without waiting for clk:
- force IDLE;
- clear the counter;
- set Busy=0, Done=0, Hi=0, Lo=0.
REQ-018 Reset mid-operation SHALL abort the operation, discard all partial results, and assert no Done after reset release.
REQ-019 The first Start SHALL be accepted on the first rising edge with rst_n=1.

Configuration
REQ-020 The macro MDU_DIV_EN SHALL control divide support.
- Defined: DIV and DIVU SHALL be implemented per REQ-009..011.
- Undefined: the divider datapath SHALL be absent; Start with MDOp[1]=1 SHALL be ignored (no Busy, no Done, Hi/Lo unchanged); MULT, MULTU and MTHI/MTLO SHALL be unaffected.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- MULT: SrcA=32'hFFFFFFFE (-2), SrcB=3, Start at E0 -> Busy for E1..E33, Done in cycle after E33, Hi=32'hFFFFFFFF, Lo=32'hFFFFFFFA.
- MULTU: SrcA=SrcB=32'hFFFFFFFF -> Hi=32'hFFFFFFFE, Lo=32'h00000001.
- DIV: SrcA=-7 (32'hFFFFFFF9), SrcB=2 -> Lo=32'hFFFFFFFD, Hi=32'hFFFFFFFF. DIVU: SrcA=100, SrcB=0 -> Lo=32'hFFFFFFFF, Hi=100. With MDU_DIV_EN undefined, the same DIV Start -> no Busy, Hi/Lo unchanged.
- Start at E5 during MULTU (SrcA=5, SrcB=6) -> ignored, result Lo=30, Hi=0. Also HiWe=1, WData=32'h1234 at E10 -> ignored. After Done, LoWe=1, WData=32'hABCD -> Lo=32'hABCD next edge.
- rst_n pulsed low at E16 of a MULT -> Busy=0 and Hi=Lo=0 immediately, no Done afterwards; next Start completes normally at 34 edges.
